// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point DFT output path.
// Bins are {real, imag} pairs of 32-bit signed samples, packed real-high.
package fft_pkg;

  localparam int FFT_POINTS   = 8;
  localparam int BIN_WIDTH    = 32;
  localparam int BEAT_WIDTH   = 2 * BIN_WIDTH;
  localparam int FRAME_WIDTH  = FFT_POINTS * BEAT_WIDTH;

  localparam logic [BEAT_WIDTH/8-1:0] AXIS_TKEEP = '1;

  typedef struct packed {
    logic signed [BIN_WIDTH-1:0] re;
    logic signed [BIN_WIDTH-1:0] im;
  } cbin_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  function automatic cbin_t bin_slice(input logic [FRAME_WIDTH-1:0] frame,
                                      input int unsigned k);
    return cbin_t'(frame[k*BEAT_WIDTH +: BEAT_WIDTH]);
  endfunction

endpackage

// File: rtl/fft_bin_serializer.sv
// Splits one wide DFT result frame into per-bin AXI4-Stream beats, bin 0 first.
// state   | meaning
// IDLE    | no frame held, input ready, output idle
// SEND    | frame held, presenting bin bin_idx on the master port
module fft_bin_serializer
  import fft_pkg::*;
#(
  parameter int C_AXIS_TIN_WIDTH   = FRAME_WIDTH,
  parameter int C_AXIS_TDATA_WIDTH = BEAT_WIDTH,
  parameter int C_BINS             = FFT_POINTS,
  parameter int C_BIN_IDX_WIDTH    = 3,
  parameter int C_FRAME_CNT_WIDTH  = 16
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TIN_WIDTH-1:0]     s_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_BIN_IDX_WIDTH-1:0]      m_axis_tuser,
  output logic [C_FRAME_CNT_WIDTH-1:0]    frame_count
);

  localparam logic [C_BIN_IDX_WIDTH-1:0] LAST_BIN = C_BIN_IDX_WIDTH'(C_BINS - 1);

  ser_state_t                    state;
  logic [C_BIN_IDX_WIDTH-1:0]    bin_idx;
  logic [C_BIN_IDX_WIDTH-1:0]    next_idx;
  logic [C_AXIS_TIN_WIDTH-1:0]   frame_reg;
  logic [C_AXIS_TDATA_WIDTH-1:0] frame_bins [C_BINS];
  logic                          in_hs;
  logic                          last_bin;

  for (genvar k = 0; k < C_BINS; k++) begin : g_bins
    assign frame_bins[k] = frame_reg[k*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
  end

  assign last_bin = (bin_idx == LAST_BIN);
  assign next_idx = bin_idx + 1'b1;

  // Ready on the final beat lets the next frame load in the same edge, no bubble.
  assign s_axis_tready = (state == ST_IDLE) |
                         ((state == ST_SEND) & last_bin & m_axis_tready);
  assign in_hs         = s_axis_tvalid & s_axis_tready;

  assign m_axis_tkeep  = '1;
  assign m_axis_tuser  = bin_idx;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state         <= ST_IDLE;
      bin_idx       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      frame_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_hs) begin
            frame_reg     <= s_axis_tdata;
            m_axis_tdata  <= s_axis_tdata[C_AXIS_TDATA_WIDTH-1:0];
            bin_idx       <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            state         <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (m_axis_tready) begin
            if (last_bin) begin
              frame_count  <= frame_count + 1'b1;
              bin_idx      <= '0;
              m_axis_tlast <= 1'b0;
              if (in_hs) begin
                frame_reg    <= s_axis_tdata;
                m_axis_tdata <= s_axis_tdata[C_AXIS_TDATA_WIDTH-1:0];
              end else begin
                m_axis_tvalid <= 1'b0;
                state         <= ST_IDLE;
              end
            end else begin
              bin_idx      <= next_idx;
              m_axis_tdata <= frame_bins[next_idx];
              m_axis_tlast <= (next_idx == LAST_BIN);
            end
          end
        end

        default: begin
          state         <= ST_IDLE;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Randomized bench for fft_bin_serializer against a queue-of-beats reference model.
// A second instance with a 2-bit frame counter shares all inputs to exercise wrap.
module tb_fft_bin_serializer;
  import fft_pkg::*;

  typedef struct {
    logic [63:0] data;
    int          idx;
  } beat_t;

  logic         clk;
  logic         s_axis_areset;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tlast;
  logic [2:0]   m_axis_tuser;
  logic [15:0]  frame_count;

  logic         w_tready, w_tvalid, w_tlast;
  logic [63:0]  w_tdata;
  logic [7:0]   w_tkeep;
  logic [2:0]   w_tuser;
  logic [1:0]   w_frame_count;

  fft_bin_serializer dut (
    .s_axis_aclk  (clk),
    .s_axis_areset(s_axis_areset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .frame_count  (frame_count)
  );

  fft_bin_serializer #(.C_FRAME_CNT_WIDTH(2)) dut_w (
    .s_axis_aclk  (clk),
    .s_axis_areset(s_axis_areset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(w_tready),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tvalid(w_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (w_tdata),
    .m_axis_tkeep (w_tkeep),
    .m_axis_tlast (w_tlast),
    .m_axis_tuser (w_tuser),
    .frame_count  (w_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t q[$];
  int    fc_model = 0;
  logic  s_hs_now, m_hs_now;

  function automatic logic [511:0] rand_frame();
    logic [511:0] f;
    for (int k = 0; k < 8; k++) f[k*64 +: 64] = {$urandom(), $urandom()};
    return f;
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input logic sv, input logic [511:0] sd, input logic mr);
    logic exp_valid, exp_ready;
    logic [15:0] exp_fc;
    beat_t b;
    @(negedge clk);
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    m_axis_tready = mr;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() == 0) || (q.size() == 1 && mr);
    exp_fc    = 16'(fc_model);
    n_checks++;
    if (m_axis_tvalid !== exp_valid)
      $display("FAIL tvalid: got %b expected %b", m_axis_tvalid, exp_valid);
    else n_pass++;
    n_checks++;
    if (s_axis_tready !== exp_ready)
      $display("FAIL s_tready: got %b expected %b", s_axis_tready, exp_ready);
    else n_pass++;
    if (exp_valid) begin
      b = q[0];
      n_checks++;
      if (m_axis_tdata !== b.data)
        $display("FAIL tdata: got %h expected %h", m_axis_tdata, b.data);
      else n_pass++;
      n_checks++;
      if (m_axis_tuser !== 3'(b.idx))
        $display("FAIL tuser: got %0d expected %0d", m_axis_tuser, b.idx);
      else n_pass++;
      n_checks++;
      if (m_axis_tlast !== (b.idx == 7))
        $display("FAIL tlast: got %b expected %b", m_axis_tlast, (b.idx == 7));
      else n_pass++;
    end
    n_checks++;
    if (frame_count !== exp_fc)
      $display("FAIL frame_count: got %0d expected %0d", frame_count, exp_fc);
    else n_pass++;
    n_checks++;
    if (w_frame_count !== exp_fc[1:0])
      $display("FAIL frame_count_w2: got %0d expected %0d", w_frame_count, exp_fc[1:0]);
    else n_pass++;
    s_hs_now = sv && exp_ready;
    m_hs_now = exp_valid && mr;
    if (m_hs_now) begin
      if (q[0].idx == 7) fc_model++;
      void'(q.pop_front());
    end
    if (s_hs_now)
      for (int k = 0; k < 8; k++) q.push_back('{data: bin_slice(sd, k), idx: k});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    s_axis_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (cycles) @(negedge clk);
    s_axis_areset = 1'b0;
    q.delete();
    fc_model = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 3'd0)
      $display("FAIL reset_outputs: got v=%b l=%b u=%0d expected 0/0/0",
               m_axis_tvalid, m_axis_tlast, m_axis_tuser);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'd0 || s_axis_tready !== 1'b1)
      $display("FAIL reset_count_ready: got fc=%0d rdy=%b expected 0/1", frame_count, s_axis_tready);
    else n_pass++;
    n_checks++;
    if (m_axis_tkeep !== AXIS_TKEEP)
      $display("FAIL tkeep: got %h expected %h", m_axis_tkeep, AXIS_TKEEP);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [511:0] f;
    cbin_t b;
    int seen7 = 0;
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      b.re = 32'(k * 16 + 1);
      b.im = -32'(k + 1);
      f[k*64 +: 64] = b;
    end
    step(1'b1, f, 1'b1);
    for (int c = 0; c < 9; c++) begin
      step(1'b0, '0, 1'b1);
      if (m_axis_tvalid && m_axis_tuser == 3'd7) begin
        seen7++;
        n_checks++;
        if (m_axis_tdata !== 64'h00000071_FFFFFFF8 || m_axis_tlast !== 1'b1)
          $display("FAIL single_bin7: got %h last=%b expected 00000071fffffff8 last=1",
                   m_axis_tdata, m_axis_tlast);
        else n_pass++;
      end
    end
    n_checks++;
    if (seen7 != 1 || frame_count !== 16'd1)
      $display("FAIL single_done: got bin7_beats=%0d fc=%0d expected 1/1", seen7, frame_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [511:0] frames [3];
    int sent = 0, beats = 0, first_c = -1, last_c = -1, pulses = 0;
    do_reset(1);
    for (int i = 0; i < 3; i++) frames[i] = rand_frame();
    for (int c = 0; c < 40 && beats < 24; c++) begin
      step(sent < 3, frames[sent < 3 ? sent : 0], 1'b1);
      if (m_axis_tvalid && s_axis_tready) pulses++;
      if (s_hs_now) sent++;
      if (m_hs_now) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        beats++;
      end
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (beats != 24 || (last_c - first_c) != 23)
      $display("FAIL b2b_contiguous: got beats=%0d span=%0d expected 24/23",
               beats, last_c - first_c);
    else n_pass++;
    n_checks++;
    if (pulses != 3 || frame_count !== 16'd3)
      $display("FAIL b2b_frames: got ready_pulses=%0d fc=%0d expected 3/3", pulses, frame_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int sent = 0, beats = 0, early = 0;
    logic [511:0] f;
    do_reset(1);
    f = rand_frame();
    for (int c = 0; c < 400 && beats < 32; c++) begin
      step(sent < 4, f, 1'($urandom_range(0, 1)));
      if (s_hs_now) begin
        if (m_axis_tvalid && !(m_axis_tlast && m_axis_tready)) early++;
        sent++;
        f = rand_frame();
      end
      if (m_hs_now) beats++;
    end
    n_checks++;
    if (beats != 32 || early != 0)
      $display("FAIL backpressure: got beats=%0d early_accepts=%0d expected 32/0", beats, early);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [511:0] fa, fb;
    int accepted_at7 = 0, after = 0;
    logic chk_next = 1'b0;
    do_reset(1);
    fa = rand_frame();
    fb = rand_frame();
    step(1'b1, fa, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(c >= 2 && accepted_at7 == 0, fb, 1'b1);
      if (chk_next) begin
        chk_next = 1'b0;
        after++;
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 3'd0 || m_axis_tdata !== fb[63:0])
          $display("FAIL simul_next_bin0: got v=%b u=%0d d=%h expected 1/0/%h",
                   m_axis_tvalid, m_axis_tuser, m_axis_tdata, fb[63:0]);
        else n_pass++;
      end
      if (s_hs_now) begin
        if (m_axis_tvalid && m_axis_tlast) begin
          accepted_at7++;
          chk_next = 1'b1;
        end
      end
    end
    n_checks++;
    if (accepted_at7 != 1 || after != 1 || frame_count !== 16'd2)
      $display("FAIL simul_summary: got acc=%0d next=%0d fc=%0d expected 1/1/2",
               accepted_at7, after, frame_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    do_reset(1);
    step(1'b1, rand_frame(), 1'b1);
    for (int c = 0; c < 9; c++) step(1'b0, '0, 1'b1);
    step(1'b1, rand_frame(), 1'b1);
    for (int c = 0; c < 10 && beats < 3; c++) begin
      step(1'b0, '0, 1'b1);
      if (m_hs_now) beats++;
    end
    do_reset(1);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || frame_count !== 16'd0 || m_axis_tlast !== 1'b0)
      $display("FAIL reset_mid: got v=%b fc=%0d l=%b expected 0/0/0",
               m_axis_tvalid, frame_count, m_axis_tlast);
    else n_pass++;
    step(1'b1, rand_frame(), 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 3'd0)
      $display("FAIL reset_restart: got v=%b u=%0d expected 1/0", m_axis_tvalid, m_axis_tuser);
    else n_pass++;
    for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int sent = 0, done = 0;
    logic pending = 1'b0;
    do_reset(1);
    for (int c = 0; c < 80 && done < 5; c++) begin
      step(sent < 5, rand_frame(), 1'b1);
      if (pending) begin
        pending = 1'b0;
        n_checks++;
        if (w_frame_count !== exp_seq[done])
          $display("FAIL wrap_seq%0d: got %0d expected %0d", done, w_frame_count, exp_seq[done]);
        else n_pass++;
        done++;
      end
      if (s_hs_now) sent++;
      if (m_hs_now && m_axis_tlast) pending = 1'b1;
    end
    if (pending) begin
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (w_frame_count !== exp_seq[done])
        $display("FAIL wrap_seq%0d: got %0d expected %0d", done, w_frame_count, exp_seq[done]);
      else n_pass++;
      done++;
    end
    n_checks++;
    if (done != 5)
      $display("FAIL wrap_count: got %0d frames expected 5", done);
    else n_pass++;
  endtask

  initial begin
    s_axis_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
